// File: rtl/cam_capture_dec.sv
// cam_capture_dec: camera byte-to-pixel capture stage with optional decimation.
// Oversamples the asynchronous camera pins on clk, assembles two-byte pixels
// (RGB444, RGB565 or YUV422 luma), keeps every C_DEC-th pixel/line and writes
// packed pixels to the frame buffer.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   pclk, href, vsync   camera byte clock, line valid, frame sync (async)
//   data                camera byte (async, valid at pclk rise)
//   fmt, swap_r_b       pixel format / red-blue swap, latched at frame start
//   enable              capture enable, sampled at frame start
//   addr, dout, we      frame buffer write port (we is a one-clk strobe)
//   frame_done          one-clk pulse at the end of a captured frame
//   line_err            one-clk pulse when a line's pixel count != C_IMG_COLS
module cam_capture_dec #(
  parameter int C_IMG_COLS = 160,
  parameter int C_IMG_ROWS = 120,
  parameter int C_DEC      = 1,
  parameter int C_NB_R     = 4,
  parameter int C_NB_G     = 4,
  parameter int C_NB_B     = 4,
  parameter int C_VS_FILT  = 4,
  localparam int C_NB_BUF  = C_NB_R + C_NB_G + C_NB_B,
  localparam int C_OCOLS   = C_IMG_COLS / C_DEC,
  localparam int C_OROWS   = C_IMG_ROWS / C_DEC,
  localparam int C_NB_ADDR = $clog2(C_OCOLS * C_OROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pclk,
  input  logic                 href,
  input  logic                 vsync,
  input  logic [7:0]           data,
  input  logic [1:0]           fmt,
  input  logic                 swap_r_b,
  input  logic                 enable,
  output logic [C_NB_ADDR-1:0] addr,
  output logic [C_NB_BUF-1:0]  dout,
  output logic                 we,
  output logic                 frame_done,
  output logic                 line_err
);

  localparam int CW  = $clog2(C_IMG_COLS + 2);  // column counter saturates at COLS+1
  localparam int RW  = $clog2(C_IMG_ROWS + 1);  // row counter saturates at ROWS
  localparam int DSH = $clog2(C_DEC);
  localparam int VW  = $clog2(C_VS_FILT + 1);

  localparam logic [CW-1:0]        COLS_V  = CW'(C_IMG_COLS);
  localparam logic [CW-1:0]        COL_SAT = CW'(C_IMG_COLS + 1);
  localparam logic [CW-1:0]        DMASK_C = CW'(C_DEC - 1);
  localparam logic [CW-1:0]        OCOLS_C = CW'(C_OCOLS);
  localparam logic [RW-1:0]        ROWS_V  = RW'(C_IMG_ROWS);
  localparam logic [RW-1:0]        DMASK_R = RW'(C_DEC - 1);
  localparam logic [RW-1:0]        OROWS_R = RW'(C_OROWS);
  localparam logic [C_NB_ADDR-1:0] OCOLS_A = C_NB_ADDR'(C_OCOLS);
  localparam logic [VW-1:0]        VS_MAX  = VW'(C_VS_FILT);
  localparam logic [VW-1:0]        VS_THR  = VW'(C_VS_FILT - 1);

  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_ACTIVE, S_SKIP} state_t;
  state_t state_q, state_d;

  // input synchronisers: bit 0 = rg1 ... bit 2 = rg3
  logic [2:0] pclk_sr, href_sr, vs_sr;
  logic [7:0] data_rg1, data_rg2, data_rg3;
  logic       href_d;

  logic pclk_rise, href_rg3, vsync_rg3, href_fall;
  assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
  assign href_rg3  = href_sr[2];
  assign vsync_rg3 = vs_sr[2];
  assign href_fall = href_d & ~href_rg3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vs_sr    <= '0;
      data_rg1 <= '0;
      data_rg2 <= '0;
      data_rg3 <= '0;
      href_d   <= 1'b0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], pclk};
      href_sr  <= {href_sr[1:0], href};
      vs_sr    <= {vs_sr[1:0], vsync};
      data_rg1 <= data;
      data_rg2 <= data_rg1;
      data_rg3 <= data_rg2;
      href_d   <= href_rg3;
    end
  end

  // vsync glitch filter: vs_cnt holds the number of preceding consecutive
  // high samples, so vs_ok marks the C_VS_FILT-th one and stays high after.
  logic [VW-1:0] vs_cnt;
  logic          vs_ok;
  assign vs_ok = vsync_rg3 && (vs_cnt >= VS_THR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  vs_cnt <= '0;
    else if (!vsync_rg3)      vs_cnt <= '0;
    else if (vs_cnt != VS_MAX) vs_cnt <= vs_cnt + VW'(1);
  end

  // frame FSM
  logic frame_end, cfg_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    cfg_load  = 1'b0;
    case (state_q)
      S_IDLE:  if (vs_ok) state_d = S_VSYNC;
      S_VSYNC: if (!vsync_rg3) begin
        cfg_load = 1'b1;
        state_d  = enable ? S_ACTIVE : S_SKIP;
      end
      S_ACTIVE: if (vs_ok) begin
        frame_end = 1'b1;
        state_d   = S_VSYNC;
      end
      S_SKIP:  if (vs_ok) state_d = S_VSYNC;
      default: state_d = S_IDLE;
    endcase
  end

  // pixel formatting from stored byte0 and the current (byte1) sample
  logic [1:0]          fmt_q;
  logic                swap_q;
  logic [7:0]          b0_q;
  logic [4:0]          r5, b5, rs, bs;
  logic [5:0]          g6;
  logic [C_NB_BUF-1:0] rgb_pix, gray_pix, pix;

  always_comb begin
    if (fmt_q == 2'b00) begin
      r5 = {b0_q[3:0], 1'b0};
      g6 = {data_rg3[7:4], 2'b00};
      b5 = {data_rg3[3:0], 1'b0};
    end else begin
      r5 = b0_q[7:3];
      g6 = {b0_q[2:0], data_rg3[7:5]};
      b5 = data_rg3[4:0];
    end
    rs      = swap_q ? b5 : r5;
    bs      = swap_q ? r5 : b5;
    rgb_pix = {C_NB_R'(rs >> (5 - C_NB_R)), C_NB_G'(g6 >> (6 - C_NB_G)),
               C_NB_B'(bs >> (5 - C_NB_B))};
    pix     = fmt_q[1] ? gray_pix : rgb_pix;
  end

  if (C_NB_BUF <= 8) begin : g_gray_msb
    assign gray_pix = C_NB_BUF'(b0_q >> (8 - C_NB_BUF));
  end else begin : g_gray_ext
    assign gray_pix = {{(C_NB_BUF - 8){1'b0}}, b0_q};
  end

  // line/frame counters; base holds (row/C_DEC)*C_OCOLS, advanced once per
  // line end so a short or long line never shifts later lines.
  logic [CW-1:0]        col;
  logic [RW-1:0]        row, row_nx;
  logic [C_NB_ADDR-1:0] base;
  logic                 tog, keep, adv;

  assign row_nx = row + RW'(1);
  assign keep   = ((col & DMASK_C) == '0) && ((row & DMASK_R) == '0) &&
                  ((col >> DSH) < OCOLS_C) && ((row >> DSH) < OROWS_R);
  assign adv    = ((row_nx & DMASK_R) == '0) && ((row_nx >> DSH) < OROWS_R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      fmt_q      <= '0;
      swap_q     <= 1'b0;
      b0_q       <= '0;
      col        <= '0;
      row        <= '0;
      base       <= '0;
      tog        <= 1'b0;
    end else begin
      we         <= 1'b0;
      line_err   <= 1'b0;
      frame_done <= frame_end;
      if (cfg_load) begin
        fmt_q  <= fmt;
        swap_q <= swap_r_b;
      end
      // a frame end (vs_ok) overrides any line end or pixel in the same cycle
      if (state_q != S_ACTIVE || vs_ok) begin
        col  <= '0;
        row  <= '0;
        base <= '0;
        tog  <= 1'b0;
      end else if (href_fall) begin
        line_err <= (col != COLS_V);
        if (row != ROWS_V) begin
          row <= row_nx;
          if (adv) base <= base + OCOLS_A;
        end
        col <= '0;
        tog <= 1'b0;
      end else if (href_rg3 && pclk_rise) begin
        if (!tog) begin
          b0_q <= data_rg3;
          tog  <= 1'b1;
        end else begin
          tog <= 1'b0;
          if (keep) begin
            we   <= 1'b1;
            addr <= base + C_NB_ADDR'(col >> DSH);
            dout <= pix;
          end
          if (col != COL_SAT) col <= col + CW'(1);
        end
      end
    end
  end

endmodule
